reg_sequencer: RTL and testbench
================================

Name: reg_sequencer

Overview:
Multi-cycle instruction sequencer that drives the 4-entry x 8-bit register file's control strobes (read X/Y, write, hi/lo nibble load, move). Accepts 8-bit instructions over a valid/ready handshake and steps each one through read, ALU-execute and writeback phases. Handshakes with a possibly multi-cycle ALU. Sits between the instruction source and the register file/ALU pair.

Parameters:
ALU_TIMEOUT, 15, max cycles in EXEC waiting for alu_done before abort (1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction/immediate byte valid
instr  input  8  [7:4] opcode, [3:2] r1, [1:0] r2; 2nd byte of LDHI/LDLO = immediate
instr_ready  output  1  sequencer accepts a byte this cycle
alu_done  input  1  ALU result valid on result bus
alu_go  output  1  start ALU operation
alu_op  output  4  latched opcode to ALU
r1  output  2  latched destination/X register index
r2  output  2  latched source/Y register index
immediate  output  6  {2'b00, imm[3:0]}
reg_r_en, reg_readx_en, reg_ready_en, reg_w_en, reg_hi_en, reg_lo_en, reg_swap_en  output  1 each  register file strobes
busy  output  1  high whenever state != IDLE
illegal  output  1  1-cycle pulse: illegal opcode accepted
timeout  output  1  1-cycle pulse: ALU wait aborted

Behaviour:
- Opcodes: 0x0-0x7 binary ALU (read X,Y; writeback); 0x8 MOV (mem[r1]<=mem[r2]); 0x9 LDHI; 0xA LDLO; 0xB unary ALU (read X only; writeback); 0xC CMP (read X,Y; no writeback); 0xF NOP; 0xD/0xE illegal.
- States: IDLE, IMM, LOADI, READ, EXEC, WB, MOVE, ERR. Outputs are Moore: decoded from state and latched fields only; no input-to-output combinational path except none.
- instr_ready=1 only in IDLE and IMM. Transfer = instr_valid & instr_ready.
- IDLE, transfer: latch opcode/r1/r2. Next state: ALU/unary/CMP -> READ; MOV -> MOVE; LDHI/LDLO -> IMM; NOP -> IDLE; illegal -> ERR.
- READ (1 cycle): reg_r_en=1, reg_readx_en=1; reg_ready_en=1 unless unary. -> EXEC.
- EXEC: alu_go=1 first EXEC cycle only. Wait counter cleared on entry, incremented each EXEC cycle. alu_done sampled every EXEC cycle including the first. alu_done -> WB (ALU/unary) or IDLE (CMP). Counter reaches ALU_TIMEOUT with no alu_done -> ERR with timeout source, no writeback.
- WB (1 cycle): reg_w_en=1. -> IDLE.
- MOVE (1 cycle): reg_swap_en=1. -> IDLE.
- IMM: wait for transfer; latch instr[3:0] as imm (instr[7:4] ignored). -> LOADI.
- LOADI (1 cycle): reg_hi_en=1 for LDHI, else reg_lo_en=1; immediate={2'b00,imm}. -> IDLE.
- ERR (1 cycle): illegal=1 or timeout=1 per cause. -> IDLE.
- At most one of reg_w_en/reg_hi_en/reg_lo_en/reg_swap_en high in any cycle. All strobes 0 in IDLE and IMM.
- alu_op, r1, r2, immediate hold their latched values until the next IDLE/IMM transfer.
- Latency, binary op with alu_done on first EXEC cycle: accept T, READ T+1, EXEC T+2, WB T+3, instr_ready again T+4.
- Reset value (cycle after reset high): state IDLE; every strobe, alu_go, illegal, timeout, busy = 0. alu_op, r1, r2, immediate, imm, counter = 0. Reset mid-operation aborts with no strobe in the following cycle; no pending write completes.
- instr_valid deasserted in IMM: sequencer waits indefinitely (busy=1).

Test Plan:
- Reset, then instr=0x16 (op1,r1=1,r2=2) with alu_done high on first EXEC -> READ at T+1 with r_en/readx/ready=1, alu_go at T+2, reg_w_en at T+3 with r1=1, instr_ready=1 at T+4.
- instr=0x96 then 0x0A -> reg_hi_en=1 for one cycle with r1=1 and immediate=6'h0A; reg_lo_en, reg_w_en, reg_swap_en stay 0. Repeat with 0xA6 -> reg_lo_en only.
- instr=0x8E (MOV r1=3,r2=2) -> reg_swap_en one cycle at T+1, busy=0 at T+2. Then 0xF0 (NOP) -> no strobes, busy never set.
- instr=0xD0 -> illegal pulse at T+1, no strobes. Binary op with alu_done never asserted -> timeout pulse after 15 EXEC cycles, no reg_w_en.
- Unary 0xB4 -> reg_ready_en=0 in READ. CMP 0xC5 -> no WB. Assert reset during EXEC -> IDLE next cycle, all outputs 0, no write.
- LDHI with instr_valid held low 5 cycles in IMM -> instr_ready=1 and busy=1 throughout. Load completes on 6th cycle.

Source files
------------

// File: rtl/reg_sequencer.sv
// Multi-cycle instruction sequencer for the 4x8 register file and its ALU.
// Outputs are registered from the next state, so every strobe lines up with its state.
module reg_sequencer #(
    parameter int ALU_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    input  logic       alu_done,
    output logic       alu_go,
    output logic [3:0] alu_op,
    output logic [1:0] r1,
    output logic [1:0] r2,
    output logic [5:0] immediate,
    output logic       reg_r_en,
    output logic       reg_readx_en,
    output logic       reg_ready_en,
    output logic       reg_w_en,
    output logic       reg_hi_en,
    output logic       reg_lo_en,
    output logic       reg_swap_en,
    output logic       busy,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE, IMM, LOADI, READ, EXEC, WB, MOVE, ERR
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_LDHI = 4'h9;
    localparam logic [3:0] OP_LDLO = 4'hA;
    localparam logic [3:0] OP_UN   = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_NOP  = 4'hF;

    state_t     state;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic [3:0] imm;
    logic       transfer;

    assign transfer  = instr_valid & instr_ready;
    assign immediate = {2'b00, imm};

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (transfer) begin
                    case (instr[7:4])
                        OP_MOV:           nxt = MOVE;
                        OP_LDHI, OP_LDLO: nxt = IMM;
                        OP_UN, OP_CMP:    nxt = READ;
                        OP_NOP:           nxt = IDLE;
                        4'hD, 4'hE:       nxt = ERR;
                        default:          nxt = READ;
                    endcase
                end
            end
            IMM:   nxt = transfer ? LOADI : IMM;
            READ:  nxt = EXEC;
            EXEC: begin
                // A done on the final allowed cycle still wins over the abort.
                if (alu_done)
                    nxt = (alu_op == OP_CMP) ? IDLE : WB;
                else if (int'(wait_cnt) + 1 >= ALU_TIMEOUT)
                    nxt = ERR;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            imm          <= '0;
            alu_op       <= '0;
            r1           <= '0;
            r2           <= '0;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            alu_go       <= 1'b0;
            reg_r_en     <= 1'b0;
            reg_readx_en <= 1'b0;
            reg_ready_en <= 1'b0;
            reg_w_en     <= 1'b0;
            reg_hi_en    <= 1'b0;
            reg_lo_en    <= 1'b0;
            reg_swap_en  <= 1'b0;
            illegal      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state <= nxt;

            if (state == IDLE && transfer) begin
                alu_op <= instr[7:4];
                r1     <= instr[3:2];
                r2     <= instr[1:0];
            end
            if (state == IMM && transfer)
                imm <= instr[3:0];

            wait_cnt <= (state == EXEC) ? wait_cnt + 8'd1 : 8'd0;

            // Strobes for the cycle we are about to enter.
            instr_ready  <= (nxt == IDLE) || (nxt == IMM);
            busy         <= (nxt != IDLE);
            alu_go       <= (nxt == EXEC) && (state == READ);
            reg_r_en     <= (nxt == READ);
            reg_readx_en <= (nxt == READ);
            reg_ready_en <= (nxt == READ) && (instr[7:4] != OP_UN);
            reg_w_en     <= (nxt == WB);
            reg_hi_en    <= (nxt == LOADI) && (alu_op == OP_LDHI);
            reg_lo_en    <= (nxt == LOADI) && (alu_op != OP_LDHI);
            reg_swap_en  <= (nxt == MOVE);
            illegal      <= (nxt == ERR) && (state == IDLE);
            timeout      <= (nxt == ERR) && (state == EXEC);
        end
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: directed scenarios then random instructions
// against a transaction-level model of the expected per-cycle strobes.
module tb_reg_sequencer;

    localparam int TMO = 15;

    localparam logic [11:0] RDY = 12'h800, BSY = 12'h400, GO  = 12'h200,
                            R   = 12'h100, X   = 12'h080, Y   = 12'h040,
                            W   = 12'h020, HI  = 12'h010, LO  = 12'h008,
                            SW  = 12'h004, ILL = 12'h002, TO  = 12'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       alu_done;
    logic       alu_go;
    logic [3:0] alu_op;
    logic [1:0] r1, r2;
    logic [5:0] immediate;
    logic       reg_r_en, reg_readx_en, reg_ready_en, reg_w_en;
    logic       reg_hi_en, reg_lo_en, reg_swap_en;
    logic       busy, illegal, timeout;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_op, m_imm;
    logic [1:0] m_r1, m_r2;

    always #5 clk = ~clk;

    reg_sequencer #(.ALU_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_done(alu_done), .alu_go(alu_go),
        .alu_op(alu_op), .r1(r1), .r2(r2), .immediate(immediate),
        .reg_r_en(reg_r_en), .reg_readx_en(reg_readx_en),
        .reg_ready_en(reg_ready_en), .reg_w_en(reg_w_en),
        .reg_hi_en(reg_hi_en), .reg_lo_en(reg_lo_en),
        .reg_swap_en(reg_swap_en), .busy(busy), .illegal(illegal),
        .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] e);
        logic [11:0] obs;
        logic [13:0] fobs, fexp;
        obs  = {instr_ready, busy, alu_go, reg_r_en, reg_readx_en, reg_ready_en,
                reg_w_en, reg_hi_en, reg_lo_en, reg_swap_en, illegal, timeout};
        fobs = {alu_op, r1, r2, immediate};
        fexp = {m_op, m_r1, m_r2, 2'b00, m_imm};
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s strobes observed=%h expected=%h", tag, obs, e);
        end
        vectors++;
        assert (fobs === fexp) else begin
            miscompares++;
            $error("FAIL %s fields observed=%h expected=%h", tag, fobs, fexp);
        end
    endtask

    // One complete instruction: dly = EXEC cycle index carrying alu_done
    // (>= TMO means never), iwait = idle cycles in the immediate wait.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] immb,
                             input int dly, input int iwait);
        logic [3:0] op;
        bit done;
        op = ins[7:4];
        instr = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = 8'($urandom);
        m_op = op;
        m_r1 = ins[3:2];
        m_r2 = ins[1:0];
        if (op < 4'h8 || op == 4'hB || op == 4'hC) begin
            chk("read", BSY | R | X | ((op == 4'hB) ? 12'h000 : Y));
            done = 1'b0;
            for (int k = 0; k < TMO; k++) begin
                tick();
                chk("exec", BSY | ((k == 0) ? GO : 12'h000));
                alu_done = (k == dly);
                if (k == dly) begin
                    done = 1'b1;
                    break;
                end
            end
            tick();
            alu_done = 1'b0;
            if (!done) begin
                chk("timeout", BSY | TO);
                tick();
            end else if (op != 4'hC) begin
                chk("wb", BSY | W);
                tick();
            end
            chk("idle_after_alu", RDY);
        end else if (op == 4'h8) begin
            chk("move", BSY | SW);
            tick();
            chk("idle_after_mov", RDY);
        end else if (op == 4'h9 || op == 4'hA) begin
            chk("imm", RDY | BSY);
            for (int k = 0; k < iwait; k++) begin
                tick();
                chk("imm_wait", RDY | BSY);
            end
            instr = immb;
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            m_imm = immb[3:0];
            chk("loadi", BSY | ((op == 4'h9) ? HI : LO));
            tick();
            chk("idle_after_load", RDY);
        end else if (op == 4'hF) begin
            chk("nop", RDY);
        end else begin
            chk("illegal", BSY | ILL);
            tick();
            chk("idle_after_err", RDY);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 8'h00;
        alu_done = 1'b0;
        m_op = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
        tick();
        tick();
        chk("reset", RDY);
        reset = 1'b0;
        tick();
        chk("idle", RDY);

        run_instr(8'h16, 8'h00, 0, 0);     // binary op, done on first EXEC
        run_instr(8'h96, 8'h0A, 0, 0);     // LDHI
        run_instr(8'hA6, 8'hF3, 0, 0);     // LDLO, upper nibble ignored
        run_instr(8'h8E, 8'h00, 0, 0);     // MOV
        run_instr(8'hF0, 8'h00, 0, 0);     // NOP
        run_instr(8'hD0, 8'h00, 0, 0);     // illegal
        run_instr(8'hE5, 8'h00, 0, 0);     // illegal
        run_instr(8'h27, 8'h00, 99, 0);    // ALU timeout
        run_instr(8'h3B, 8'h00, TMO - 1, 0); // done on last allowed cycle
        run_instr(8'hB4, 8'h00, 2, 0);     // unary
        run_instr(8'hC5, 8'h00, 1, 0);     // CMP
        run_instr(8'h97, 8'h55, 0, 5);     // LDHI with a 5-cycle stall

        // Reset while waiting in EXEC: nothing completes afterwards.
        instr = 8'h16;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        m_op = 4'h1; m_r1 = 2'd1; m_r2 = 2'd2;
        chk("rst_read", BSY | R | X | Y);
        tick();
        chk("rst_exec", BSY | GO);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_op = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
        chk("rst_abort", RDY);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("rst_no_wb", RDY);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] ins, immb;
            int dly, iw;
            ins  = 8'($urandom);
            immb = 8'($urandom);
            dly  = ($urandom_range(0, 6) == 0) ? 40 : int'($urandom_range(0, 4));
            iw   = int'($urandom_range(0, 3));
            run_instr(ins, immb, dly, iw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
